// File: rtl/heartbeat_pkg.sv
// Shared types and constants for the heartbeat line receiver.
package heartbeat_pkg;

   typedef enum logic [1:0] {
      HUNT_PHASE = 2'd0,
      HUNT_WORD  = 2'd1,
      LOCKED     = 2'd2
   } hb_state_e;

   localparam int         HB_WORD_BITS = 8;
   localparam int         HB_HALF_CLKS = 2;
   localparam logic [7:0] HB_CNT_MAX   = 8'd255;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == HB_CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/manchester_pair_slicer.sv
// Groups registered line samples into (first, second) half-bit pairs and
// decodes them; owns the half-bit phase flag, which holds for one clock on slip.
module manchester_pair_slicer
   import heartbeat_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sample,
   input  logic slip,
   output logic bit_valid,
   output logic bit_value,
   output logic violation
);

   localparam int              PW        = $clog2(HB_HALF_CLKS);
   localparam logic [PW-1:0]   PH_SECOND = PW'(HB_HALF_CLKS - 1);

   logic [PW-1:0] phase_q, phase_d;
   logic          first_q, first_d;
   logic          pair_end;

   always_comb begin
      first_d   = sample;
      pair_end  = (phase_q == PH_SECOND);
      violation = pair_end && (first_q == sample);
      bit_valid = pair_end && (first_q != sample);
      bit_value = first_q;
      // Holding the phase instead of advancing it re-pairs the stream one clock later.
      phase_d   = slip ? phase_q : phase_q + PW'(1);
   end

   always_ff @(posedge clk) begin
      first_q <= first_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= '0;
      end else begin
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/heartbeat_monitor.sv
// Heartbeat line receiver: phase/word alignment, sequence check, lock status.
// Define HEARTBEAT_MONITOR_STATS_EN to implement the code/sequence error counters.
//
// state      | meaning
// HUNT_PHASE | counting consecutive good Manchester pairs, slipping on violations
// HUNT_WORD  | assembling candidate words, slipping one bit on a failed +1 match
// LOCKED     | emitting words, tracking consecutive sequence mismatches
module heartbeat_monitor
   import heartbeat_pkg::*;
#(
   parameter int PHASE_LOCK_PAIRS  = 16,
   parameter int WORD_LOCK_MATCHES = 2,
   parameter int LOSS_MISMATCHES   = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       signal,
   output logic [7:0] data,
   output logic       data_valid,
   output logic       locked,
   output logic [7:0] code_err_count,
   output logic [7:0] seq_err_count
);

   localparam int GW = $clog2(PHASE_LOCK_PAIRS + 1);
   localparam int MW = $clog2(WORD_LOCK_MATCHES + 1);
   localparam int LW = $clog2(LOSS_MISMATCHES + 1);
   localparam int BW = $clog2(HB_WORD_BITS);

   localparam logic [GW-1:0] GOOD_LAST  = GW'(PHASE_LOCK_PAIRS - 1);
   localparam logic [MW-1:0] MATCH_LAST = MW'(WORD_LOCK_MATCHES - 1);
   localparam logic [LW-1:0] MISS_LAST  = LW'(LOSS_MISMATCHES - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(HB_WORD_BITS - 1);

   hb_state_e                state_q, state_d;
   logic                     sig_q, sig_d;
   logic [GW-1:0]            good_cnt_q, good_cnt_d;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [MW-1:0]            match_cnt_q, match_cnt_d;
   logic [LW-1:0]            miss_cnt_q, miss_cnt_d;
   logic [HB_WORD_BITS-1:0]  shift_q, shift_d;
   logic [HB_WORD_BITS-1:0]  cand_q, cand_d;
   logic                     have_cand_q, have_cand_d;
   logic                     skip_q, skip_d;
   logic [7:0]               data_q, data_d;
   logic                     data_valid_q, data_valid_d;

   logic                     bit_valid, bit_value, violation, slip;
   logic [HB_WORD_BITS-1:0]  word_next;
   logic                     seq_ok;

   assign sig_d = signal;

   always_ff @(posedge clk) begin
      sig_q <= sig_d;
   end

   assign slip = (state_q == HUNT_PHASE) && violation;

   manchester_pair_slicer u_slicer (
      .clk       (clk),
      .rst       (rst),
      .sample    (sig_q),
      .slip      (slip),
      .bit_valid (bit_valid),
      .bit_value (bit_value),
      .violation (violation)
   );

   assign word_next = {shift_q[HB_WORD_BITS-2:0], bit_value};
   assign seq_ok    = (word_next == cand_q + 8'd1);

   always_comb begin
      state_d      = state_q;
      good_cnt_d   = good_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      match_cnt_d  = match_cnt_q;
      miss_cnt_d   = miss_cnt_q;
      shift_d      = shift_q;
      cand_d       = cand_q;
      have_cand_d  = have_cand_q;
      skip_d       = skip_q;
      data_d       = data_q;
      data_valid_d = 1'b0;

      unique case (state_q)
         HUNT_PHASE: begin
            if (violation) begin
               good_cnt_d = '0;
            end else if (bit_valid) begin
               if (good_cnt_q == GOOD_LAST) begin
                  state_d     = HUNT_WORD;
                  good_cnt_d  = '0;
                  bit_cnt_d   = '0;
                  match_cnt_d = '0;
                  have_cand_d = 1'b0;
                  skip_d      = 1'b0;
               end else begin
                  good_cnt_d = good_cnt_q + GW'(1);
               end
            end
         end

         HUNT_WORD: begin
            if (violation) begin
               state_d    = HUNT_PHASE;
               good_cnt_d = '0;
            end else if (bit_valid) begin
               if (skip_q) begin
                  skip_d = 1'b0;
               end else begin
                  shift_d = word_next;
                  if (bit_cnt_q == BIT_LAST) begin
                     bit_cnt_d   = '0;
                     cand_d      = word_next;
                     have_cand_d = 1'b1;
                     if (have_cand_q) begin
                        if (seq_ok) begin
                           if (match_cnt_q == MATCH_LAST) begin
                              state_d    = LOCKED;
                              miss_cnt_d = '0;
                           end else begin
                              match_cnt_d = match_cnt_q + MW'(1);
                           end
                        end else begin
                           // The word after a slip has no valid predecessor, so it is stored only.
                           match_cnt_d = '0;
                           skip_d      = 1'b1;
                           have_cand_d = 1'b0;
                        end
                     end
                  end else begin
                     bit_cnt_d = bit_cnt_q + BW'(1);
                  end
               end
            end
         end

         LOCKED: begin
            if (violation) begin
               state_d    = HUNT_PHASE;
               good_cnt_d = '0;
            end else if (bit_valid) begin
               shift_d = word_next;
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  cand_d    = word_next;
                  if (seq_ok) begin
                     miss_cnt_d   = '0;
                     data_d       = word_next;
                     data_valid_d = 1'b1;
                  end else if (miss_cnt_q == MISS_LAST) begin
                     state_d    = HUNT_PHASE;
                     good_cnt_d = '0;
                     miss_cnt_d = '0;
                  end else begin
                     miss_cnt_d   = miss_cnt_q + LW'(1);
                     data_d       = word_next;
                     data_valid_d = 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end

         default: begin
            state_d = HUNT_PHASE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HUNT_PHASE;
         good_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         match_cnt_q  <= '0;
         miss_cnt_q   <= '0;
         shift_q      <= '0;
         cand_q       <= '0;
         have_cand_q  <= 1'b0;
         skip_q       <= 1'b0;
         data_q       <= '0;
         data_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         good_cnt_q   <= good_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         match_cnt_q  <= match_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
         shift_q      <= shift_d;
         cand_q       <= cand_d;
         have_cand_q  <= have_cand_d;
         skip_q       <= skip_d;
         data_q       <= data_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign data       = data_q;
   assign data_valid = data_valid_q;
   assign locked     = (state_q == LOCKED);

`ifdef HEARTBEAT_MONITOR_STATS_EN
   logic [7:0] code_err_q, code_err_d;
   logic [7:0] seq_err_q, seq_err_d;
   logic       seq_err_inc;

   assign seq_err_inc = (state_q == LOCKED) && bit_valid && (bit_cnt_q == BIT_LAST) && !seq_ok;

   always_comb begin
      code_err_d = violation   ? sat_inc(code_err_q) : code_err_q;
      seq_err_d  = seq_err_inc ? sat_inc(seq_err_q)  : seq_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_err_q <= '0;
         seq_err_q  <= '0;
      end else begin
         code_err_q <= code_err_d;
         seq_err_q  <= seq_err_d;
      end
   end

   assign code_err_count = code_err_q;
   assign seq_err_count  = seq_err_q;
`else
   assign code_err_count = '0;
   assign seq_err_count  = '0;
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Directed bench for heartbeat_monitor: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_heartbeat_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       signal;
   logic [7:0] data;
   logic       data_valid;
   logic       locked;
   logic [7:0] code_err_count;
   logic [7:0] seq_err_count;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic       locked_seen;

`ifdef HEARTBEAT_MONITOR_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   always #5 clk = ~clk;

   heartbeat_monitor dut (
      .clk            (clk),
      .rst            (rst),
      .signal         (signal),
      .data           (data),
      .data_valid     (data_valid),
      .locked         (locked),
      .code_err_count (code_err_count),
      .seq_err_count  (seq_err_count)
   );

   function automatic int stat(input int v);
      return STATS ? v : 0;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (data_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_strobe: got data %0d, expected no strobe (t=%0t)", data, $time);
         end else begin
            check("strobe_data", int'(data), int'(exp_q.pop_front()));
            check("strobe_locked", int'(locked), 1);
         end
      end
   end

   task automatic half(input logic v, input logic r);
      rst    = r;
      signal = v;
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] w, input int from, input int flip, input logic r0);
      logic b;
      for (int i = from; i < 8; i++) begin
         b = w[7-i];
         half(b ^ (flip == 2*i), r0 && (i == from));
         half(~b ^ (flip == 2*i + 1), 1'b0);
      end
   endtask

   task automatic send_word(input logic [7:0] w, input bit expect_strobe, input int flip);
      if (expect_strobe) exp_q.push_back(w);
      send_bits(w, 0, flip, 1'b0);
   endtask

   task automatic check_reset_outputs();
      check("rst_data", int'(data), 0);
      check("rst_data_valid", int'(data_valid), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_code_err", int'(code_err_count), 0);
      check("rst_seq_err", int'(seq_err_count), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = 1'b1;
      signal = 1'b0;
      repeat (4) half(1'b0, 1'b1);
      check_reset_outputs();

      // Clean stream from 0x00; first half-bit is sampled with rst still high.
      send_bits(8'h00, 0, -1, 1'b1);
      for (int w = 1; w <= 15; w++) begin
         send_word(8'(w), w >= 5, -1);
         if (w == 3) check("locked_before_match", int'(locked), 0);
         if (w == 6) check("locked_clean_start", int'(locked), 1);
      end

      // Single skipped value
      send_word(8'h10, 1, -1);
      send_word(8'h12, 1, -1);
      send_word(8'h13, 1, -1);
      check("locked_after_one_jump", int'(locked), 1);
      check("seq_err_one_jump", int'(seq_err_count), stat(1));

      // Two consecutive skips drop lock
      for (int w = 8'h14; w <= 8'h20; w++) send_word(8'(w), 1, -1);
      send_word(8'h22, 1, -1);
      send_word(8'h24, 0, -1);
      send_word(8'h25, 0, -1);
      check("locked_after_two_jumps", int'(locked), 0);
      check("seq_err_two_jumps", int'(seq_err_count), stat(3));
      for (int w = 8'h26; w <= 8'h29; w++) send_word(8'(w), 0, -1);
      for (int w = 8'h2A; w <= 8'h3F; w++) begin
         send_word(8'(w), 1, -1);
         if (w == 8'h2B) check("relock_after_loss", int'(locked), 1);
      end

      // Corrupt the second half of the LSB of 0x40
      send_word(8'h40, 0, 15);
      check("locked_same_cycle_as_violation", int'(locked), 1);
      half(1'b0, 1'b0);
      check("locked_falls_after_violation", int'(locked), 0);
      check("code_err_one", int'(code_err_count), stat(1));
      half(1'b1, 1'b0);
      send_bits(8'h41, 1, -1, 1'b0);
      for (int w = 8'h42; w <= 8'h45; w++) send_word(8'(w), 0, -1);
      for (int w = 8'h46; w <= 8'hFF; w++) begin
         send_word(8'(w), 1, -1);
         if (w == 8'h47) check("relock_after_violation", int'(locked), 1);
      end
      for (int w = 0; w <= 3; w++) send_word(8'(w), 1, -1);
      check("locked_after_wrap", int'(locked), 1);
      check("seq_err_after_wrap", int'(seq_err_count), stat(3));
      check("code_err_after_wrap", int'(code_err_count), stat(1));

      // Partial word 0x04, then a one-cycle rst mid-lock
      for (int i = 0; i < 4; i++) begin
         half(1'b0, 1'b0);
         half(1'b1, 1'b0);
      end
      check("queue_empty_before_rst", exp_q.size(), 0);
      half(1'b1, 1'b1);
      check_reset_outputs();
      half(1'b0, 1'b0);
      send_bits(8'h80, 1, -1, 1'b0);
      for (int w = 8'h81; w <= 8'h84; w++) send_word(8'(w), 0, -1);
      for (int w = 8'h85; w <= 8'h8F; w++) send_word(8'(w), 1, -1);
      half(1'b1, 1'b0);
      half(1'b0, 1'b0);
      check("relock_after_rst_pulse", int'(locked), 1);
      check("queue_empty_after_rst_relock", exp_q.size(), 0);
      check("code_err_after_rst", int'(code_err_count), 0);
      check("seq_err_after_rst", int'(seq_err_count), 0);

      // Line stuck at 0
      half(1'b0, 1'b1);
      half(1'b0, 1'b1);
      locked_seen = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         half(1'b0, 1'b0);
         if (locked === 1'b1) locked_seen = 1'b1;
      end
      check("stuck_locked_never", int'(locked_seen), 0);
      check("stuck_code_err_saturates", int'(code_err_count), stat(255));
      check("stuck_seq_err", int'(seq_err_count), 0);
      check("stuck_no_strobes_pending", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
